// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB RX packet sequencer.
package usb_rx_pkg;

  // Largest legal packet after the PID: 64 payload bytes plus CRC16.
  localparam int unsigned MaxBytes = 66;

  typedef enum logic [2:0] {
    StIdle,
    StReceive,
    StDrain,
    StCheck,
    StDone,
    StFlush,
    StErr
  } state_e;

  typedef enum logic [1:0] {
    TypeToken  = 2'd0,
    TypeData   = 2'd1,
    TypeHshake = 2'd2,
    TypeBad    = 2'd3
  } pkt_type_e;

  typedef enum logic [2:0] {
    ErrNone     = 3'd0,
    ErrRx       = 3'd1,
    ErrOverflow = 3'd2,
    ErrBadLen   = 3'd3,
    ErrBadPid   = 3'd4
  } err_code_e;

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidSetup = 4'b1101;
  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidData1 = 4'b1011;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidStall = 4'b1110;

endpackage

// File: rtl/usb_pid_classify.sv
// Maps a PID to its packet class and judges the byte count against that class.
module usb_pid_classify
  import usb_rx_pkg::*;
#(
  parameter int unsigned CNT_W = 7
) (
  input  logic [3:0]       pid_i,
  input  logic [CNT_W-1:0] count_i,
  output logic [1:0]       type_o,
  output logic             len_ok_o
);

  // Class decode plus length rule for that class.
  always_comb begin
    type_o   = TypeBad;
    len_ok_o = 1'b0;
    case (pid_i)
      PidOut, PidIn, PidSetup: begin
        type_o   = TypeToken;
        len_ok_o = (count_i == CNT_W'(2));
      end
      PidData0, PidData1: begin
        type_o   = TypeData;
        len_ok_o = (count_i >= CNT_W'(2));
      end
      PidAck, PidNak, PidStall: begin
        type_o   = TypeHshake;
        len_ok_o = (count_i == '0);
      end
      default: begin
        type_o   = TypeBad;
        len_ok_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// Drains the RX FIFO toward the AHB side, counts bytes, validates each packet
// and reports exactly one done or error pulse per packet.
module usb_rx_pkt_ctrl
  import usb_rx_pkg::*;
#(
  parameter int unsigned MAX_BYTES = MaxBytes,
  parameter int unsigned CNT_W     = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_empty,
  input  logic             rcving,
  input  logic             rx_error,
  input  logic [3:0]       rx_pid,
  output logic             r_enable,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] byte_count,
  output logic             pkt_done,
  output logic             pkt_err,
  output logic [2:0]       err_code,
  output logic [3:0]       pkt_pid,
  output logic [1:0]       pkt_type
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BYTES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       err_q, err_d;
  logic [3:0]       pid_q, pid_d;
  logic [1:0]       type_q, type_d;
  logic [1:0]       cls_type;
  logic             cls_len_ok;

  usb_pid_classify #(
    .CNT_W (CNT_W)
  ) u_classify (
    .pid_i    (rx_pid),
    .count_i  (cnt_q),
    .type_o   (cls_type),
    .len_ok_o (cls_len_ok)
  );

  // Next-state, FIFO handshake and pulse generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    pid_d     = pid_q;
    type_d    = type_q;
    out_valid = 1'b0;
    r_enable  = 1'b0;
    pkt_done  = 1'b0;
    pkt_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Level-sensitive so a packet starting during DONE/ERR is still caught.
        if (rcving) begin
          cnt_d   = '0;
          err_d   = ErrNone;
          state_d = StReceive;
        end
      end
      StReceive, StDrain: begin
        if (rx_error) begin
          err_d   = ErrRx;
          state_d = StFlush;
        end else if (!rx_empty && (cnt_q == MaxCnt)) begin
          // Overflowing byte is discarded silently; the count stays saturated.
          r_enable = 1'b1;
          err_d    = ErrOverflow;
          state_d  = StFlush;
        end else begin
          out_valid = !rx_empty;
          r_enable  = out_valid & out_ready;
          if (r_enable) cnt_d = cnt_q + CNT_W'(1);
          if (state_q == StReceive) begin
            if (!rcving) state_d = StDrain;
          end else if (rx_empty) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        pid_d  = rx_pid;
        type_d = cls_type;
        if (cls_type == TypeBad) begin
          err_d   = ErrBadPid;
          state_d = StErr;
        end else if (!cls_len_ok) begin
          err_d   = ErrBadLen;
          state_d = StErr;
        end else begin
          state_d = StDone;
        end
      end
      StFlush: begin
        r_enable = !rx_empty;
        if (rx_empty && !rcving) begin
          pid_d   = rx_pid;
          type_d  = cls_type;
          state_d = StErr;
        end
      end
      StDone: begin
        pkt_done = 1'b1;
        state_d  = StIdle;
      end
      StErr: begin
        pkt_err = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= '0;
      pid_q   <= '0;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pid_q   <= pid_d;
      type_q  <= type_d;
    end
  end

  assign out_data   = out_valid ? rx_data : 8'h00;
  assign byte_count = cnt_q;
  assign err_code   = err_q;
  assign pkt_pid    = pid_q;
  assign pkt_type   = type_q;

endmodule

// File: doc/usb_rx_pkt_ctrl.md
Name: usb_rx_pkt_ctrl

Overview:
Packet-level sequencer that sits between the USB receiver (RX FIFO, PID, rcving/r_error status) and the AHB slave data path. It drains the RX FIFO with a ready/valid handshake toward the AHB side and counts bytes per packet. It classifies the PID, checks packet length against PID type, and reports one done or error event per packet. On error it flushes residual FIFO bytes so the next packet starts clean.

Parameters:
MAX_BYTES, 66, maximum bytes per packet after the PID (64 payload + 2 CRC16); one more byte is an overflow.
CNT_W, 7, width of the byte counter; must satisfy 2**CNT_W > MAX_BYTES.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
rx_data  input  8  RX FIFO head byte; first-word fall-through, valid whenever rx_empty=0.
rx_empty  input  1  RX FIFO empty.
rcving  input  1  receiver is mid-packet (level).
rx_error  input  1  receiver error flag (level, held until next packet).
rx_pid  input  4  PID decoded by receiver; stable from first data byte to end of packet.
r_enable  output  1  RX FIFO pop strobe; pops the head byte at this clock edge.
out_data  output  8  byte forwarded to AHB side (equals rx_data).
out_valid  output  1  out_data valid.
out_ready  input  1  AHB side accepts out_data this cycle.
byte_count  output  CNT_W  bytes forwarded in the current or last packet.
pkt_done  output  1  one-cycle pulse: packet completed without error.
pkt_err  output  1  one-cycle pulse: packet terminated with error.
err_code  output  3  error cause, valid with pkt_err and held until the next packet starts.
pkt_pid  output  4  PID latched at end of packet, held until the next end of packet.
pkt_type  output  2  class of pkt_pid: TOKEN, DATA, HSHAKE, BAD.

Behaviour:
- Reset values: all outputs 0. State is IDLE. FIFO contents are untouched. Reset mid-packet abandons the packet with no pulse.
- States: IDLE, RECEIVE, DRAIN, CHECK, DONE, FLUSH, ERR.
- IDLE: byte_count held. If rcving=1 (level, so back-to-back packets are not lost): clear byte_count, clear err_code, go to RECEIVE.
- RECEIVE / DRAIN forwarding: out_valid = !rx_empty; r_enable = out_valid & out_ready, combinational, zero latency. Each pop increments byte_count.
- Overflow: a pop when byte_count == MAX_BYTES sets err_code=OVERFLOW and goes to FLUSH. The overflowing byte is still popped, but out_valid is suppressed that cycle.
- RECEIVE: rx_error=1 -> FLUSH with err_code=RX_ERR. rcving falls with rx_error=0 -> DRAIN. If rx_error and the rcving fall happen in the same cycle, the error wins.
- DRAIN: forward until rx_empty=1, then go to CHECK. rx_error=1 here still goes to FLUSH with RX_ERR.
- CHECK (1 cycle): latch pkt_pid=rx_pid and pkt_type. Length rules:
  - TOKEN (OUT 0001, IN 1001, SETUP 1101): exactly 2 bytes.
  - DATA (DATA0 0011, DATA1 1011): >=2 bytes.
  - HSHAKE (ACK 0010, NAK 1010, STALL 1110): 0 bytes.
  - Any other PID -> BAD.
  - Pass -> DONE. Length fail -> ERR with BAD_LEN. BAD type -> ERR with BAD_PID.
- FLUSH: out_valid=0; r_enable = !rx_empty regardless of out_ready. Stay until rx_empty=1 and rcving=0, then latch pkt_pid/pkt_type and go to ERR.
- DONE: pkt_done=1 for one cycle, then IDLE. ERR: pkt_err=1 for one cycle, then IDLE.
- pkt_done and pkt_err are never asserted together.
- out_valid and r_enable are 0 in IDLE, CHECK, DONE and ERR.
- err_code encoding: NONE=0, RX_ERR=1, OVERFLOW=2, BAD_LEN=3, BAD_PID=4.
- byte_count saturates at MAX_BYTES and never wraps.
- Back-pressure: out_ready=0 holds out_valid and the byte with no pop. The FIFO may fill; the receiver's full handling is outside this block.

Decomposition:
- Package usb_rx_pkg holds:
  - state enum
  - pkt_type enum
  - err_code enum
  - PID constants (OUT, IN, SETUP, DATA0, DATA1, ACK, NAK, STALL)
  - MAX_BYTES default
- Sub-module usb_pid_classify: combinational, maps 4-bit PID to pkt_type and the per-type length rule.

Test Plan:
- DATA0 packet, 5 bytes {A1,B2,C3,D4,E5}, out_ready=1 -> 5 pops in order, byte_count=5, pkt_done 1 cycle, pkt_pid=0011, pkt_type=DATA, err_code=0.
- IN token, 2 bytes, out_ready toggling 1/0 each cycle -> no pop while ready=0, data order preserved, pkt_done, pkt_type=TOKEN; same token with 3 bytes -> pkt_err, err_code=3.
- rx_error raised after 2 of 6 bytes -> remaining FIFO bytes flushed with out_valid=0, pkt_err, err_code=1, rx_empty=1 at exit.
- 67-byte DATA1 packet, MAX_BYTES=66 -> 66 bytes forwarded, 67th popped silently, flush, pkt_err, err_code=2, byte_count=66.
- ACK (0 bytes) followed immediately by rcving re-asserted for next packet -> pkt_done for ACK, then RECEIVE entered with byte_count=0, no packet lost; PID 0111 packet -> pkt_err, err_code=4.
- n_rst asserted mid-RECEIVE -> all outputs 0 asynchronously, IDLE, no pulse; next packet handled normally.
